ul_frame_receiver: RTL and testbench

Parametrised uplink frame receiver: recovers bit timing from a serial preamble, samples a message ID and a variable-width payload, checks parity and presents the frame on a valid/ready interface. It is the full-datapath successor of the uplink monitor, with training, sampling and deserialisation in one block, and sits between the uplink pad and the FEC decoder front end.

---
 rtl/fec_pkg.sv | 26 ++
 rtl/ul_bit_sampler.sv | 49 ++++
 rtl/ul_frame_receiver.sv | 209 ++++++++++++++++++++
 tb/tb_ul_frame_receiver.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fec_pkg
// Brief    : Shared types and constants for the uplink frame receiver.
// Revision : 1.0 - initial release
// ============================================================================
package fec_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TRAINING = 3'd1,
        S_ID       = 3'd2,
        S_DATA     = 3'd3,
        S_PARITY   = 3'd4,
        S_DONE     = 3'd5
    } ul_rx_state_t;

    // Additive descrambler x^7+x^6+1: key is the XOR of state bits 6 and 5.
    localparam logic [6:0] UL_LFSR_SEED = 7'h7F;
    localparam logic [6:0] UL_LFSR_TAPS = 7'h60;

    localparam int UL_PREAMBLE_COUNT = 8;
    localparam int UL_MIN_CLK_DIV    = 4;

endpackage
`default_nettype wire

// File: rtl/ul_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module   : ul_bit_sampler
// Brief    : Bit-period phase counter with optional resync on ul_in edges;
//            strobes sample_stb at mid-bit (phase == clk_div>>1).
// Revision : 1.0 - initial release
// ============================================================================
module ul_bit_sampler #(
    parameter int SERIAL_DIV_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SERIAL_DIV_WIDTH-1:0] clk_div,
    input  logic                        resync_en,
    input  logic                        ul_in,
    output logic                        sample_stb,
    output logic                        sample_bit
);

    logic [SERIAL_DIV_WIDTH-1:0] phase_q;
    logic [SERIAL_DIV_WIDTH-1:0] phase_d;
    logic                        ul_prev_q;
    logic                        w_edge;

    assign w_edge = resync_en && (ul_in != ul_prev_q);

    // >= rather than == keeps the counter bounded if clk_div shrinks mid-count.
    always_comb begin
        phase_d = phase_q + SERIAL_DIV_WIDTH'(1);
        if (w_edge || (phase_q >= clk_div - SERIAL_DIV_WIDTH'(1))) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= '0;
            ul_prev_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            ul_prev_q <= ul_in;
        end
    end

    assign sample_stb = !w_edge && (phase_q == (clk_div >> 1));
    assign sample_bit = ul_in;

endmodule
`default_nettype wire

// File: rtl/ul_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ul_frame_receiver
// Brief    : Uplink frame receiver: preamble lock, ID/data/parity capture and
//            a one-entry valid/ready output register. Optional descrambler
//            enabled by defining UL_DESCRAMBLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ul_frame_receiver
    import fec_pkg::*;
#(
    parameter int SERIAL_DIV_WIDTH = 8,
    parameter int PREAMBLE_COUNT   = UL_PREAMBLE_COUNT,
    parameter int ID_WIDTH         = 4,
    parameter int DATA_WIDTH       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SERIAL_DIV_WIDTH-1:0] clk_div,
    input  logic                        ul_in,
    input  logic                        ul_en,
    output logic [ID_WIDTH-1:0]         msg_id,
    output logic [DATA_WIDTH-1:0]       msg_data,
    output logic                        msg_err,
    output logic                        msg_valid,
    input  logic                        msg_ready,
    output logic                        locked,
    output logic                        overflow
);

    localparam int C_TC_W  = $clog2(PREAMBLE_COUNT + 1);
    localparam int C_MAX_W = (ID_WIDTH > DATA_WIDTH) ? ID_WIDTH : DATA_WIDTH;
    localparam int C_BC_W  = $clog2(C_MAX_W + 1);
    localparam logic [C_TC_W-1:0]           c_PRE_CNT   = C_TC_W'(PREAMBLE_COUNT);
    localparam logic [C_BC_W-1:0]           c_ID_LAST   = C_BC_W'(ID_WIDTH - 1);
    localparam logic [C_BC_W-1:0]           c_DATA_LAST = C_BC_W'(DATA_WIDTH - 1);
    localparam logic [SERIAL_DIV_WIDTH-1:0] c_MIN_DIV   = SERIAL_DIV_WIDTH'(UL_MIN_CLK_DIV);

    ul_rx_state_t          state_q, state_d;
    logic [C_TC_W-1:0]     train_cnt_q, train_cnt_d, w_train_nx;
    logic [C_BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [ID_WIDTH-1:0]   id_sr_q, id_sr_d, out_id_q, out_id_d;
    logic [DATA_WIDTH-1:0] data_sr_q, data_sr_d, out_data_q, out_data_d;
    logic                  par_err_q, par_err_d, out_err_q, out_err_d;
    logic                  out_valid_q, out_valid_d, overflow_q, overflow_d;
    logic                  w_stb, w_sample_bit, w_key, w_rx_bit, w_locked, w_resync_en;

    ul_bit_sampler #(
        .SERIAL_DIV_WIDTH (SERIAL_DIV_WIDTH)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .resync_en  (w_resync_en),
        .ul_in      (ul_in),
        .sample_stb (w_stb),
        .sample_bit (w_sample_bit)
    );

`ifdef UL_DESCRAMBLE_EN
    logic [6:0] lfsr_q, lfsr_d;

    assign w_key = ^(lfsr_q & UL_LFSR_TAPS);

    // Held at the seed throughout training so it is seeded on entry to S_ID.
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == S_TRAINING) begin
            lfsr_d = UL_LFSR_SEED;
        end else if (w_stb && ((state_q == S_ID) || (state_q == S_DATA))) begin
            lfsr_d = {lfsr_q[5:0], w_key};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= '0;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign w_key = 1'b0;
`endif

    assign w_rx_bit = w_sample_bit ^ w_key;

    // Even count means the next preamble bit should be a 1.
    assign w_train_nx = (w_sample_bit == ~train_cnt_q[0]) ? (train_cnt_q + 1'b1)
                                                          : C_TC_W'(w_sample_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (ul_en && (clk_div >= c_MIN_DIV)) state_d = S_TRAINING;
            S_TRAINING: if (w_stb && (w_train_nx == c_PRE_CNT)) state_d = S_ID;
            S_ID:       if (w_stb && (bit_cnt_q == c_ID_LAST)) state_d = S_DATA;
            S_DATA:     if (w_stb && (bit_cnt_q == c_DATA_LAST)) state_d = S_PARITY;
            S_PARITY:   if (w_stb) state_d = S_DONE;
            S_DONE:     state_d = S_TRAINING;
            default:    state_d = S_IDLE;
        endcase
        if (!ul_en) state_d = S_IDLE;
    end

    always_comb begin
        w_locked    = 1'b0;
        w_resync_en = 1'b0;
        case (state_q)
            S_ID, S_DATA, S_PARITY: w_locked    = 1'b1;
            S_TRAINING:             w_resync_en = 1'b1;
            default:                ;
        endcase
    end

    always_comb begin
        train_cnt_d = train_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        id_sr_d     = id_sr_q;
        data_sr_d   = data_sr_q;
        par_err_d   = par_err_q;
        case (state_q)
            S_IDLE: begin
                train_cnt_d = '0;
                bit_cnt_d   = '0;
                id_sr_d     = '0;
                data_sr_d   = '0;
            end
            S_TRAINING: begin
                bit_cnt_d = '0;
                if (w_stb) train_cnt_d = w_train_nx;
            end
            S_ID: begin
                train_cnt_d = '0;
                if (w_stb) begin
                    id_sr_d   = (id_sr_q << 1) | ID_WIDTH'(w_rx_bit);
                    bit_cnt_d = (bit_cnt_q == c_ID_LAST) ? '0 : bit_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (w_stb) begin
                    data_sr_d = (data_sr_q << 1) | DATA_WIDTH'(w_rx_bit);
                    bit_cnt_d = (bit_cnt_q == c_DATA_LAST) ? '0 : bit_cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (w_stb) par_err_d = ^{id_sr_q, data_sr_q, w_sample_bit};
            end
            default: ;
        endcase
    end

    // A completed frame is dropped only when the held one is not leaving this cycle.
    always_comb begin
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        overflow_d  = 1'b0;
        if (out_valid_q && msg_ready) out_valid_d = 1'b0;
        if (state_q == S_DONE) begin
            if (out_valid_q && !msg_ready) begin
                overflow_d = 1'b1;
            end else begin
                out_id_d    = id_sr_q;
                out_data_d  = data_sr_q;
                out_err_d   = par_err_q;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            train_cnt_q <= '0;
            bit_cnt_q   <= '0;
            id_sr_q     <= '0;
            data_sr_q   <= '0;
            par_err_q   <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            train_cnt_q <= train_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            id_sr_q     <= id_sr_d;
            data_sr_q   <= data_sr_d;
            par_err_q   <= par_err_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign msg_id    = out_id_q;
    assign msg_data  = out_data_q;
    assign msg_err   = out_err_q;
    assign msg_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign locked    = w_locked;

endmodule
`default_nettype wire

// File: tb/tb_ul_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ul_frame_receiver
// Brief    : Directed self-checking bench for ul_frame_receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ul_frame_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  clk_div;
    logic        ul_in;
    logic        ul_en;
    logic        msg_ready;
    logic [3:0]  msg_id;
    logic [15:0] msg_data;
    logic        msg_err;
    logic        msg_valid;
    logic        locked;
    logic        overflow;

    int total   = 0;
    int bad     = 0;
    int bitlen  = 8;
    int ovf_cnt = 0;
    int lck_cnt = 0;

    ul_frame_receiver #(
        .SERIAL_DIV_WIDTH (8),
        .PREAMBLE_COUNT   (8),
        .ID_WIDTH         (4),
        .DATA_WIDTH       (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_div   (clk_div),
        .ul_in     (ul_in),
        .ul_en     (ul_en),
        .msg_id    (msg_id),
        .msg_data  (msg_data),
        .msg_err   (msg_err),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .locked    (locked),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overflow) ovf_cnt++;
        if (locked)   lck_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ul_in = b;
        repeat (bitlen) tick();
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 8; i++) send_bit(~i[0]);
    endtask

    task automatic send_body(input logic [3:0] id, input logic [15:0] data);
        logic [19:0] bits;
        logic        key;
`ifdef UL_DESCRAMBLE_EN
        logic [6:0]  lfsr;
        lfsr = 7'h7F;
`endif
        bits = {id, data};
        for (int i = 19; i >= 0; i--) begin
`ifdef UL_DESCRAMBLE_EN
            key  = lfsr[6] ^ lfsr[5];
            lfsr = {lfsr[5:0], key};
`else
            key  = 1'b0;
`endif
            send_bit(bits[i] ^ key);
        end
    endtask

    task automatic send_frame(input logic [3:0] id, input logic [15:0] data, input logic flip);
        send_bit(1'b0);
        send_bit(1'b0);
        send_preamble();
        send_body(id, data);
        send_bit((^{id, data}) ^ flip);
        send_bit(1'b0);
        send_bit(1'b0);
    endtask

    task automatic drain();
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ul_en = 1'b0; ul_in = 1'b0; msg_ready = 1'b0; clk_div = 8'd8;
        repeat (3) tick();
        total++;
        if ({msg_valid, msg_id, msg_data, msg_err, locked, overflow} !== 24'h0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b id=%h d=%h e=%b l=%b o=%b want all 0",
                     msg_valid, msg_id, msg_data, msg_err, locked, overflow);
        end
        rst = 1'b0;
        tick();
        ul_en = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        send_bit(1'b0);
        send_bit(1'b0);
        send_preamble();
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL nominal_lock: got %b want 1", locked); end
        send_body(4'hA, 16'h1234);
        send_bit(1'b1);  // A has 2 ones, 1234 has 5: parity bit 1 makes the total even
        send_bit(1'b0);
        send_bit(1'b0);
        total++;
        if (msg_valid !== 1'b1) begin bad++; $display("FAIL nominal_valid: got %b want 1", msg_valid); end
        total++;
        if (msg_id !== 4'hA) begin bad++; $display("FAIL nominal_id: got %h want a", msg_id); end
        total++;
        if (msg_data !== 16'h1234) begin bad++; $display("FAIL nominal_data: got %h want 1234", msg_data); end
        total++;
        if (msg_err !== 1'b0) begin bad++; $display("FAIL nominal_err: got %b want 0", msg_err); end
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL nominal_unlock: got %b want 0", locked); end
    endtask

    task automatic test_bad_parity();
        drain();
        send_frame(4'hA, 16'h1234, 1'b1);
        total++;
        if (msg_valid !== 1'b1) begin bad++; $display("FAIL badpar_valid: got %b want 1", msg_valid); end
        total++;
        if (msg_err !== 1'b1) begin bad++; $display("FAIL badpar_err: got %b want 1", msg_err); end
        total++;
        if (msg_data !== 16'h1234) begin bad++; $display("FAIL badpar_data: got %h want 1234", msg_data); end
    endtask

    task automatic test_broken_preamble();
        logic [12:0] pat;
        pat = 13'b1010_0_1010_1010;
        drain();
        send_bit(1'b0);
        send_bit(1'b0);
        for (int i = 12; i >= 1; i--) send_bit(pat[i]);
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL broken_early_lock: got %b want 0", locked); end
        send_bit(pat[0]);
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL broken_lock: got %b want 1", locked); end
        send_body(4'h3, 16'hA5C3);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        total++;
        if (msg_id !== 4'h3) begin bad++; $display("FAIL broken_id: got %h want 3", msg_id); end
        total++;
        if (msg_data !== 16'hA5C3) begin bad++; $display("FAIL broken_data: got %h want a5c3", msg_data); end
        total++;
        if (msg_err !== 1'b0) begin bad++; $display("FAIL broken_err: got %b want 0", msg_err); end
    endtask

    task automatic test_backpressure();
        int ovf0;
        drain();
        ovf0 = ovf_cnt;
        send_frame(4'h1, 16'h00FF, 1'b0);
        total++;
        if ({msg_valid, msg_id} !== 5'h11) begin
            bad++; $display("FAIL bp_first: got v=%b id=%h want v=1 id=1", msg_valid, msg_id);
        end
        send_frame(4'h2, 16'h0F0F, 1'b0);
        total++;
        if ((ovf_cnt - ovf0) !== 1) begin bad++; $display("FAIL bp_overflow: got %0d pulses want 1", ovf_cnt - ovf0); end
        total++;
        if (msg_id !== 4'h1) begin bad++; $display("FAIL bp_held_id: got %h want 1", msg_id); end
        total++;
        if (msg_data !== 16'h00FF) begin bad++; $display("FAIL bp_held_data: got %h want 00ff", msg_data); end
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        total++;
        if (msg_valid !== 1'b0) begin bad++; $display("FAIL bp_drop: got %b want 0", msg_valid); end
    endtask

    task automatic test_back_to_back();
        int  ovf0;
        bit  seen;
        send_frame(4'h6, 16'h5555, 1'b0);
        ovf0 = ovf_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_preamble();
        send_body(4'h3, 16'hC0DE);
        ul_in = ^{4'h3, 16'hC0DE};
        seen = 1'b0;
        for (int i = 0; i < 2 * bitlen && !seen; i++) begin
            tick();
            if (locked === 1'b0) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL b2b_done_timeout: got locked=%b want 0", locked); end
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        total++;
        if ({msg_valid, msg_id, msg_data} !== {1'b1, 4'h3, 16'hC0DE}) begin
            bad++; $display("FAIL b2b_load: got v=%b id=%h d=%h want v=1 id=3 d=c0de", msg_valid, msg_id, msg_data);
        end
        send_bit(1'b0);
        send_bit(1'b0);
        total++;
        if ((ovf_cnt - ovf0) !== 0) begin bad++; $display("FAIL b2b_overflow: got %0d pulses want 0", ovf_cnt - ovf0); end
    endtask

    task automatic test_abort();
        logic [19:0] bits;
        bits = {4'h7, 16'h1234};
        drain();
        send_bit(1'b0);
        send_bit(1'b0);
        send_preamble();
        for (int i = 19; i >= 12; i--) send_bit(bits[i]);
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL abort_pre_lock: got %b want 1", locked); end
        ul_en = 1'b0;
        tick();
        ul_en = 1'b1;
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL abort_unlock: got %b want 0", locked); end
        repeat (3) send_bit(1'b0);
        total++;
        if (msg_valid !== 1'b0) begin bad++; $display("FAIL abort_no_valid: got %b want 0", msg_valid); end
        send_frame(4'h5, 16'hBEEF, 1'b0);
        total++;
        if ({msg_valid, msg_id, msg_data, msg_err} !== {1'b1, 4'h5, 16'hBEEF, 1'b0}) begin
            bad++; $display("FAIL abort_next_frame: got v=%b id=%h d=%h e=%b want v=1 id=5 d=beef e=0",
                            msg_valid, msg_id, msg_data, msg_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] bits;
        bits = {4'h9, 16'hFFFF};
        send_bit(1'b0);
        send_bit(1'b0);
        send_preamble();
        for (int i = 19; i >= 12; i--) send_bit(bits[i]);
        total++;
        if ({locked, msg_valid} !== 2'b11) begin
            bad++; $display("FAIL rstmid_pre: got l=%b v=%b want 1 1", locked, msg_valid);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({msg_valid, msg_id, msg_data, msg_err, locked, overflow} !== 24'h0) begin
            bad++; $display("FAIL rstmid_outputs: got v=%b id=%h d=%h e=%b l=%b want all 0",
                            msg_valid, msg_id, msg_data, msg_err, locked);
        end
        tick();
        rst = 1'b0;
        ul_in = 1'b0;
        tick();
    endtask

    task automatic test_min_div();
        int l0;
        ul_en = 1'b0;
        tick();
        clk_div = 8'd3;
        ul_en = 1'b1;
        l0 = lck_cnt;
        send_frame(4'hA, 16'h1234, 1'b0);
        total++;
        if ((lck_cnt - l0) !== 0) begin bad++; $display("FAIL div3_locked: got %0d cycles want 0", lck_cnt - l0); end
        total++;
        if (msg_valid !== 1'b0) begin bad++; $display("FAIL div3_valid: got %b want 0", msg_valid); end
        ul_en = 1'b0;
        tick();
        clk_div = 8'd4;
        bitlen = 4;
        ul_en = 1'b1;
        tick();
        send_frame(4'h9, 16'h8001, 1'b0);
        total++;
        if ({msg_valid, msg_id, msg_data, msg_err} !== {1'b1, 4'h9, 16'h8001, 1'b0}) begin
            bad++; $display("FAIL div4_frame: got v=%b id=%h d=%h e=%b want v=1 id=9 d=8001 e=0",
                            msg_valid, msg_id, msg_data, msg_err);
        end
        bitlen = 8;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_parity();
        test_broken_preamble();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_min_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
